// File: rtl/control_contador_pkg.sv
// control_contador_pkg
//   Shared definitions for the round counter controller: FSM state
//   enumeration, default counter width and the round-count convention
//   (a programmed round count of 0 stands for the full 2^ANCHO rounds).
package control_contador_pkg;

  localparam int ANCHO_DEF = 4;

  // Programmed round count that is interpreted as 2^ANCHO rounds.
  localparam int RONDAS_CERO = 0;

  typedef enum logic [2:0] {
    IDLE,
    CARGA,
    CUENTA,
    PAUSA,
    FIN
  } estado_t;

  // Effective number of rounds for a programmed value.
  function automatic int rondas_totales(input int rondas, input int ancho);
    return (rondas == RONDAS_CERO) ? (1 << ancho) : rondas;
  endfunction

endpackage

// File: rtl/control_contador_contador_rst.sv
// contador_rst
//   ANCHO-bit up-counter with asynchronous active-low reset, synchronous
//   clear and increment enable. Clear has priority over increment.
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset
//   clr   - synchronous clear to 0
//   en    - increment by one (wraps modulo 2^ANCHO)
//   q     - counter value
module contador_rst
  import control_contador_pkg::*;
#(
  parameter int ANCHO = ANCHO_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [ANCHO-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= q + ANCHO'(1);
    end
  end

endmodule

// File: rtl/control_contador.sv
// control_contador
//   Round counter controller. On start, latches a terminal value (limite)
//   and a round count (rondas), then counts 0..limite repeatedly, once per
//   round, until the programmed number of rounds completes. Supports pause
//   and abort. All outputs are registered.
// Ports:
//   clk     - clock
//   rst_n   - asynchronous active-low reset
//   start   - run request, sampled only in IDLE
//   stop    - abort a run in progress (priority over everything else)
//   pausa   - freeze counting while high
//   limite  - terminal value of each round (latched at start)
//   rondas  - number of rounds, 0 = 2^ANCHO (latched at start)
//   salida  - current counter value
//   vueltas - completed rounds (modulo 2^ANCHO)
//   busy    - high in every state except IDLE
//   tc      - high during each CUENTA cycle where salida equals limite
//   done    - one-cycle pulse in FIN (normal completion)
//   abort   - one-cycle pulse in IDLE after a stop
module control_contador
  import control_contador_pkg::*;
#(
  parameter int ANCHO = ANCHO_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             pausa,
  input  logic [ANCHO-1:0] limite,
  input  logic [ANCHO-1:0] rondas,
  output logic [ANCHO-1:0] salida,
  output logic [ANCHO-1:0] vueltas,
  output logic             busy,
  output logic             tc,
  output logic             done,
  output logic             abort
);

  estado_t          state, state_next;
  logic [ANCHO-1:0] lim_reg, ron_reg, lim_next, ron_next;
  logic [ANCHO-1:0] sal_next;
  logic             sal_clr, sal_en, vue_clr, vue_en;
  logic             busy_next, tc_next, done_next, abort_next;
  logic             fin_ronda, ultima, abortar;

  assign fin_ronda = (salida == lim_reg);
  // The wrap in progress completes the last round when vueltas+1 reaches
  // the effective round count (computed in int so 2^ANCHO is representable).
  assign ultima    = ((int'(vueltas) + 1) == rondas_totales(int'(ron_reg), ANCHO));
  assign abortar   = stop && (state == CARGA || state == CUENTA || state == PAUSA);

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      lim_reg <= '0;
      ron_reg <= '0;
      busy    <= 1'b0;
      tc      <= 1'b0;
      done    <= 1'b0;
      abort   <= 1'b0;
    end else begin
      state   <= state_next;
      lim_reg <= lim_next;
      ron_reg <= ron_next;
      busy    <= busy_next;
      tc      <= tc_next;
      done    <= done_next;
      abort   <= abort_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (start && !stop) state_next = CARGA;
      CARGA:  state_next = stop ? IDLE : CUENTA;
      CUENTA: begin
        if (stop)                       state_next = IDLE;
        else if (pausa)                 state_next = PAUSA;
        else if (fin_ronda && ultima)   state_next = FIN;
      end
      PAUSA: begin
        if (stop)        state_next = IDLE;
        else if (!pausa) state_next = CUENTA;
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath controls and next values of the registered outputs
  always_comb begin
    lim_next   = lim_reg;
    ron_next   = ron_reg;
    sal_clr    = 1'b0;
    sal_en     = 1'b0;
    vue_clr    = 1'b0;
    vue_en     = 1'b0;
    abort_next = 1'b0;
    if (state == IDLE && start && !stop) begin
      lim_next = limite;
      ron_next = rondas;
      sal_clr  = 1'b1;
      vue_clr  = 1'b1;
    end else if (abortar) begin
      sal_clr    = 1'b1;
      abort_next = 1'b1;
    end else if (state == CUENTA && !pausa) begin
      if (fin_ronda) begin
        sal_clr = 1'b1;
        vue_en  = 1'b1;
      end else begin
        sal_en = 1'b1;
      end
    end
    // Mirror of the counter's next value so tc can be registered and still
    // line up with the cycle in which salida equals the limit.
    sal_next  = sal_clr ? '0 : (sal_en ? salida + ANCHO'(1) : salida);
    busy_next = (state_next != IDLE);
    done_next = (state_next == FIN);
    tc_next   = (state_next == CUENTA) && (sal_next == lim_next);
  end

  contador_rst #(.ANCHO(ANCHO)) u_salida (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (sal_clr),
    .en    (sal_en),
    .q     (salida)
  );

  contador_rst #(.ANCHO(ANCHO)) u_vueltas (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (vue_clr),
    .en    (vue_en),
    .q     (vueltas)
  );

endmodule

// File: tb/tb_control_contador.sv
module tb_control_contador;

  logic       clk, rst_n, start, stop, pausa;
  logic [3:0] limite, rondas;
  logic [3:0] salida, vueltas;
  logic       busy, tc, done, abort;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int done_mark;

  logic [3:0] b_sal [10] = '{0, 0, 1, 2, 3, 0, 1, 2, 3, 0};
  logic [3:0] b_vue [10] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 2};
  logic       b_tc  [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0};

  control_contador #(.ANCHO(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .stop    (stop),
    .pausa   (pausa),
    .limite  (limite),
    .rondas  (rondas),
    .salida  (salida),
    .vueltas (vueltas),
    .busy    (busy),
    .tc      (tc),
    .done    (done),
    .abort   (abort)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e_sal, input logic [3:0] e_vue,
                         input logic e_busy, input logic e_tc, input logic e_done, input logic e_abort);
    $display("[TB] %s: salida=%0d vueltas=%0d busy=%0b tc=%0b done=%0b abort=%0b",
             tag, salida, vueltas, busy, tc, done, abort);
    chk({tag, ".salida"},  32'(salida),  32'(e_sal));
    chk({tag, ".vueltas"}, 32'(vueltas), 32'(e_vue));
    chk({tag, ".busy"},    32'(busy),    32'(e_busy));
    chk({tag, ".tc"},      32'(tc),      32'(e_tc));
    chk({tag, ".done"},    32'(done),    32'(e_done));
    chk({tag, ".abort"},   32'(abort),   32'(e_abort));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; pausa = 1'b0;
    limite = 4'd0; rondas = 4'd0;
    #12;
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk) rst_n = 1'b1;

    // Basic run: limite=3, rondas=2
    limite = 4'd3; rondas = 4'd2; start = 1'b1;
    step();
    start = 1'b0;
    chk_all("basic0", b_sal[0], b_vue[0], 1, b_tc[0], 0, 0);
    for (int i = 1; i < 10; i++) begin
      step();
      chk_all($sformatf("basic%0d", i), b_sal[i], b_vue[i], 1, b_tc[i], (i == 9), 0);
    end
    // start during the done cycle is ignored
    start = 1'b1;
    step();
    start = 1'b0;
    chk_all("basic_idle", 0, 2, 0, 0, 0, 0);
    step();
    chk_all("start_in_fin", 0, 2, 0, 0, 0, 0);

    // Pause: limite=5, rondas=1, pause at salida=2
    limite = 4'd5; rondas = 4'd1; start = 1'b1;
    step(); start = 1'b0;
    chk_all("p_carga", 0, 0, 1, 0, 0, 0);
    step(); step(); step();
    chk_all("p_cnt2", 2, 0, 1, 0, 0, 0);
    pausa = 1'b1;
    step(); chk_all("p_hold0", 2, 0, 1, 0, 0, 0);
    step(); chk_all("p_hold1", 2, 0, 1, 0, 0, 0);
    step(); chk_all("p_hold2", 2, 0, 1, 0, 0, 0);
    pausa = 1'b0;
    step(); chk_all("p_resume", 2, 0, 1, 0, 0, 0);
    step(); chk_all("p_3", 3, 0, 1, 0, 0, 0);
    step(); chk_all("p_4", 4, 0, 1, 0, 0, 0);
    step(); chk_all("p_5", 5, 0, 1, 1, 0, 0);
    step(); chk_all("p_fin", 0, 1, 1, 0, 1, 0);
    step(); chk_all("p_idle", 0, 1, 0, 0, 0, 0);

    // Abort: limite=7, rondas=4, stop at salida=4 in round 2
    done_mark = done_cnt;
    limite = 4'd7; rondas = 4'd4; start = 1'b1;
    step(); start = 1'b0;
    for (int i = 0; i < 13; i++) step();
    chk_all("a_pre", 4, 1, 1, 0, 0, 0);
    stop = 1'b1;
    step(); stop = 1'b0;
    chk_all("a_abort", 0, 1, 0, 0, 0, 1);
    step();
    chk_all("a_after", 0, 1, 0, 0, 0, 0);
    chk("a_no_done", 32'(done_cnt), 32'(done_mark));

    // Edge values: limite=0, rondas=0 -> 16 one-cycle rounds
    limite = 4'd0; rondas = 4'd0; start = 1'b1;
    step(); start = 1'b0;
    chk_all("e_carga", 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      step();
      chk_all($sformatf("e_cnt%0d", i), 0, 4'(i), 1, 1, 0, 0);
    end
    step(); chk_all("e_fin", 0, 0, 1, 0, 1, 0);
    step(); chk_all("e_idle", 0, 0, 0, 0, 0, 0);

    // Conflicts
    start = 1'b1; stop = 1'b1; limite = 4'd2; rondas = 4'd1;
    step(); start = 1'b0; stop = 1'b0;
    chk_all("c_start_stop", 0, 0, 0, 0, 0, 0);
    stop = 1'b1;
    step(); stop = 1'b0;
    chk_all("c_stop_idle", 0, 0, 0, 0, 0, 0);
    start = 1'b1;
    step(); start = 1'b0;
    chk_all("c_carga", 0, 0, 1, 0, 0, 0);
    step(); chk_all("c_0", 0, 0, 1, 0, 0, 0);
    start = 1'b1; limite = 4'd9;
    step(); chk_all("c_1", 1, 0, 1, 0, 0, 0);
    step(); chk_all("c_2", 2, 0, 1, 1, 0, 0);
    start = 1'b0;
    step(); chk_all("c_fin", 0, 1, 1, 0, 1, 0);
    step(); chk_all("c_idle", 0, 1, 0, 0, 0, 0);

    // Async reset mid-run: limite=2, rondas=3, reset at salida=2 in round 2
    limite = 4'd2; rondas = 4'd3; start = 1'b1;
    step(); start = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk_all("r_pre", 2, 1, 1, 1, 0, 0);
    #2 rst_n = 1'b0;
    #1 chk_all("r_async", 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1 chk_all("r_release", 0, 0, 0, 0, 0, 0);
    limite = 4'd1; rondas = 4'd1; start = 1'b1;
    step(); start = 1'b0;
    chk_all("r_carga", 0, 0, 1, 0, 0, 0);
    step(); chk_all("r_0", 0, 0, 1, 0, 0, 0);
    step(); chk_all("r_1", 1, 0, 1, 1, 0, 0);
    step(); chk_all("r_fin", 0, 1, 1, 0, 1, 0);
    step(); chk_all("r_idle", 0, 1, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
